// File: rtl/wb_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter with outstanding-ack tracking.
// Define WB_ARBITER_RR_EN for round-robin; default is fixed m0 priority.
module wb_arbiter #(
  parameter int WB_ADDR_BITS = 32,
  parameter int MAX_PENDING  = 4
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst_n,
  input  logic                    i_m0_wb_cyc,
  input  logic                    i_m0_wb_stb,
  input  logic                    i_m0_wb_we,
  input  logic [WB_ADDR_BITS-1:0] i_m0_wb_addr,
  input  logic [31:0]             i_m0_wb_data,
  output logic [31:0]             o_m0_wb_data,
  output logic                    o_m0_wb_stall,
  output logic                    o_m0_wb_ack,
  input  logic                    i_m1_wb_cyc,
  input  logic                    i_m1_wb_stb,
  input  logic                    i_m1_wb_we,
  input  logic [WB_ADDR_BITS-1:0] i_m1_wb_addr,
  input  logic [31:0]             i_m1_wb_data,
  output logic [31:0]             o_m1_wb_data,
  output logic                    o_m1_wb_stall,
  output logic                    o_m1_wb_ack,
  output logic                    o_s_wb_cyc,
  output logic                    o_s_wb_stb,
  output logic                    o_s_wb_we,
  output logic [WB_ADDR_BITS-1:0] o_s_wb_addr,
  output logic [31:0]             o_s_wb_data,
  input  logic [31:0]             i_s_wb_data,
  input  logic                    i_s_wb_stall,
  input  logic                    i_s_wb_ack,
  output logic [1:0]              o_grant
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAXP = CW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t        state;
  state_t        state_nx;
  state_t        pick;
  logic [CW-1:0] pend;
  logic [CW-1:0] pend_nx;
  logic          full;
  logic          ack_v;
  logic          accept;
  logic          own_cyc;

  assign full   = (pend == MAXP);
  assign ack_v  = i_s_wb_ack && (pend != '0);
  assign accept = o_s_wb_stb && !i_s_wb_stall;

  assign o_m0_wb_data = i_s_wb_data;
  assign o_m1_wb_data = i_s_wb_data;
  assign o_grant      = state;

`ifdef WB_ARBITER_RR_EN
  logic last_m1;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      last_m1 <= 1'b1;
    end else if (state_nx != state) begin
      if (state_nx == GNT0) last_m1 <= 1'b0;
      if (state_nx == GNT1) last_m1 <= 1'b1;
    end
  end

  assign pick = last_m1 ? GNT0 : GNT1;
`else
  assign pick = GNT0;
`endif

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_m0_wb_cyc && i_m1_wb_cyc) state_nx = pick;
        else if (i_m0_wb_cyc)           state_nx = GNT0;
        else if (i_m1_wb_cyc)           state_nx = GNT1;
      end
      GNT0: begin
        if (!i_m0_wb_cyc)
          state_nx = i_m1_wb_cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!i_m1_wb_cyc)
          state_nx = i_m0_wb_cyc ? GNT0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Dropping cyc abandons the cycle: outstanding count is discarded.
  assign own_cyc = (state == GNT0 && i_m0_wb_cyc) ||
                   (state == GNT1 && i_m1_wb_cyc);

  always_comb begin
    pend_nx = pend;
    if (!own_cyc) begin
      pend_nx = '0;
    end else if (accept && !ack_v) begin
      pend_nx = pend + CW'(1);
    end else if (!accept && ack_v) begin
      pend_nx = pend - CW'(1);
    end
  end

  always_comb begin
    o_s_wb_cyc    = 1'b0;
    o_s_wb_stb    = 1'b0;
    o_s_wb_we     = 1'b0;
    o_s_wb_addr   = '0;
    o_s_wb_data   = '0;
    o_m0_wb_stall = 1'b1;
    o_m0_wb_ack   = 1'b0;
    o_m1_wb_stall = 1'b1;
    o_m1_wb_ack   = 1'b0;
    unique case (state)
      GNT0: begin
        o_s_wb_cyc    = i_m0_wb_cyc;
        o_s_wb_stb    = i_m0_wb_stb && !full;
        o_s_wb_we     = i_m0_wb_we;
        o_s_wb_addr   = i_m0_wb_addr;
        o_s_wb_data   = i_m0_wb_data;
        o_m0_wb_stall = i_s_wb_stall || full;
        o_m0_wb_ack   = ack_v;
      end
      GNT1: begin
        o_s_wb_cyc    = i_m1_wb_cyc;
        o_s_wb_stb    = i_m1_wb_stb && !full;
        o_s_wb_we     = i_m1_wb_we;
        o_s_wb_addr   = i_m1_wb_addr;
        o_s_wb_data   = i_m1_wb_data;
        o_m1_wb_stall = i_s_wb_stall || full;
        o_m1_wb_ack   = ack_v;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter.
// Multi-cycle corners (saturation, abort, hold, async reset) hand-written.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_wdat, m0_rdat;
  logic        m0_stall, m0_ack;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_wdat, m1_rdat;
  logic        m1_stall, m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdat, s_rdat;
  logic        s_stall, s_ack;
  logic [1:0]  grant;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.WB_ADDR_BITS(32), .MAX_PENDING(4)) dut (
    .i_wb_clk      (clk),
    .i_wb_rst_n    (rst_n),
    .i_m0_wb_cyc   (m0_cyc),
    .i_m0_wb_stb   (m0_stb),
    .i_m0_wb_we    (m0_we),
    .i_m0_wb_addr  (m0_addr),
    .i_m0_wb_data  (m0_wdat),
    .o_m0_wb_data  (m0_rdat),
    .o_m0_wb_stall (m0_stall),
    .o_m0_wb_ack   (m0_ack),
    .i_m1_wb_cyc   (m1_cyc),
    .i_m1_wb_stb   (m1_stb),
    .i_m1_wb_we    (m1_we),
    .i_m1_wb_addr  (m1_addr),
    .i_m1_wb_data  (m1_wdat),
    .o_m1_wb_data  (m1_rdat),
    .o_m1_wb_stall (m1_stall),
    .o_m1_wb_ack   (m1_ack),
    .o_s_wb_cyc    (s_cyc),
    .o_s_wb_stb    (s_stb),
    .o_s_wb_we     (s_we),
    .o_s_wb_addr   (s_addr),
    .o_s_wb_data   (s_wdat),
    .i_s_wb_data   (s_rdat),
    .i_s_wb_stall  (s_stall),
    .i_s_wb_ack    (s_ack),
    .o_grant       (grant)
  );

  typedef struct {
    string       nm;
    logic        c0, s0, c1, s1, st, ak;
    logic [1:0]  g;
    logic        sc, ss;
    logic [31:0] sa;
    logic        st0, ak0, st1, ak1;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input string nm,
    input logic c0, s0, c1, s1, st, ak,
    input logic [1:0] g,
    input logic sc, ss,
    input logic [31:0] sa,
    input logic st0, ak0, st1, ak1
  );
    vec_t v;
    v.nm = nm;
    v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1;
    v.st = st; v.ak = ak;
    v.g = g; v.sc = sc; v.ss = ss; v.sa = sa;
    v.st0 = st0; v.ak0 = ak0; v.st1 = st1; v.ak1 = ak1;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c0, s0, c1, s1, st, ak);
    m0_cyc = c0; m0_stb = s0;
    m1_cyc = c1; m1_stb = s1;
    s_stall = st; s_ack = ak;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " grant"}, {30'd0, grant}, 32'd0);
    chk({nm, " slave"}, {27'd0, s_cyc, s_stb, s_we,
        |s_addr, |s_wdat}, 32'd0);
    chk({nm, " masters"}, {28'd0, m0_stall, m0_ack,
        m1_stall, m1_ack}, 32'b1010);
    chk({nm, " rdata"}, m1_rdat ^ m0_rdat ^ s_rdat, s_rdat);
  endtask

  logic [1:0]  pg;
  logic [31:0] pa;
  logic        ps0, ps1;
  logic [31:0] exp_d;
  int          acc;

  initial begin
    m0_we = 1'b1; m0_addr = 32'h10; m0_wdat = 32'h41;
    m1_we = 1'b0; m1_addr = 32'h20; m1_wdat = 32'h55;
    s_rdat = 32'hCAFE_0001;
    drive(0, 0, 0, 0, 0, 0);

`ifdef WB_ARBITER_RR_EN
    pg = 2'b10; pa = 32'h20; ps0 = 1'b1; ps1 = 1'b0;
`else
    pg = 2'b01; pa = 32'h10; ps0 = 1'b0; ps1 = 1'b1;
`endif

    tv.push_back(mk("idle",     0,0,0,0,0,0, 2'b00,0,0,32'h00, 1,0,1,0));
    tv.push_back(mk("both req", 1,1,1,0,0,0, 2'b00,0,0,32'h00, 1,0,1,0));
    tv.push_back(mk("gnt0 wr",  1,1,1,0,0,0, 2'b01,1,1,32'h10, 0,0,1,0));
    tv.push_back(mk("ack0",     1,0,1,0,0,1, 2'b01,1,0,32'h10, 0,1,1,0));
    tv.push_back(mk("ack at 0", 1,0,1,0,0,1, 2'b01,1,0,32'h10, 0,0,1,0));
    tv.push_back(mk("m1 waits", 1,0,1,1,0,0, 2'b01,1,0,32'h10, 0,0,1,0));
    tv.push_back(mk("m0 drop",  0,0,1,1,0,0, 2'b01,0,0,32'h10, 0,0,1,0));
    tv.push_back(mk("gnt1 stl", 0,0,1,1,1,0, 2'b10,1,1,32'h20, 1,0,1,0));
    tv.push_back(mk("gnt1 acc", 0,0,1,1,0,0, 2'b10,1,1,32'h20, 1,0,0,0));
    tv.push_back(mk("ack1",     0,0,1,0,0,1, 2'b10,1,0,32'h20, 1,0,0,1));
    tv.push_back(mk("m1 drop",  0,0,0,0,0,0, 2'b10,0,0,32'h20, 1,0,0,0));
    tv.push_back(mk("stray ak", 0,0,0,0,0,1, 2'b00,0,0,32'h00, 1,0,1,0));
    tv.push_back(mk("m0 only",  1,0,0,0,0,0, 2'b00,0,0,32'h00, 1,0,1,0));
    tv.push_back(mk("m0 rel",   0,0,0,0,0,0, 2'b01,0,0,32'h10, 0,0,1,0));
    tv.push_back(mk("both idl", 1,0,1,0,0,0, 2'b00,0,0,32'h00, 1,0,1,0));
    tv.push_back(mk("priority", 1,0,1,0,0,0, pg,1,0,pa, ps0,0,ps1,0));
    tv.push_back(mk("both rel", 0,0,0,0,0,0, pg,0,0,pa, ps0,0,ps1,0));
    tv.push_back(mk("idle end", 0,0,0,0,0,0, 2'b00,0,0,32'h00, 1,0,1,0));

    #1;
    chk_idle("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      step();
      drive(tv[i].c0, tv[i].s0, tv[i].c1, tv[i].s1, tv[i].st, tv[i].ak);
      s_rdat = 32'hA500_0000 | i;
      @(negedge clk);
      chk({tv[i].nm, " flags"},
          {23'd0, grant, s_cyc, s_stb, m0_stall, m0_ack, m1_stall, m1_ack},
          {23'd0, tv[i].g, tv[i].sc, tv[i].ss,
           tv[i].st0, tv[i].ak0, tv[i].st1, tv[i].ak1});
      chk({tv[i].nm, " addr"}, s_addr, tv[i].sa);
      exp_d = (tv[i].g == 2'b01) ? 32'h41 :
              (tv[i].g == 2'b10) ? 32'h55 : 32'h0;
      chk({tv[i].nm, " wdat"}, {s_wdat[30:0], s_we},
          {exp_d[30:0], tv[i].g == 2'b01});
      chk({tv[i].nm, " bcast"}, {m0_rdat ^ s_rdat} | {m1_rdat ^ s_rdat}, 0);
    end

    // saturation: slave never acks while m0 keeps stb high
    step(); drive(1, 1, 0, 0, 0, 0);
    @(negedge clk); chk("sat idle grant", {30'd0, grant}, 32'd0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      if (s_stb && !s_stall) acc++;
    end
    chk("sat accepts", acc, 4);
    chk("sat stall", {31'd0, m0_stall}, 1);
    step(); drive(1, 1, 0, 0, 0, 1);
    @(negedge clk);
    chk("sat ack", {30'd0, m0_ack, s_stb}, 32'b10);
    step(); drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat reaccept", {30'd0, s_stb, m0_stall}, 32'b10);
    step();
    @(negedge clk);
    chk("sat refull", {31'd0, m0_stall}, 1);

    // abort with three outstanding
    step(); drive(1, 0, 0, 0, 0, 1);
    @(negedge clk); chk("abort pre ack", {31'd0, m0_ack}, 1);
    step(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort cyc", {29'd0, grant, s_cyc}, 32'b010);
    step(); drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("abort late ack", {29'd0, grant, m0_ack | m1_ack}, 0);

    // hold grant until acks return, m1 waiting
    step(); drive(1, 1, 0, 0, 0, 0);
    step(); drive(1, 1, 1, 0, 0, 0);
    @(negedge clk); chk("hold acc1", {30'd0, grant}, 32'b01);
    step();
    @(negedge clk); chk("hold m1 stall", {31'd0, m1_stall}, 1);
    step(); drive(1, 0, 1, 0, 0, 0);
    step(); drive(1, 0, 1, 0, 0, 1);
    @(negedge clk); chk("hold ack1", {29'd0, grant, m0_ack}, 32'b011);
    step(); drive(0, 0, 1, 0, 0, 1);
    @(negedge clk); chk("hold ack2", {29'd0, grant, m0_ack}, 32'b011);
    step(); drive(0, 0, 1, 0, 0, 0);
    @(negedge clk); chk("hold handoff", {30'd0, grant}, 32'b10);

    // async reset in GNT1 with two outstanding
    step(); drive(0, 0, 1, 1, 0, 0);
    step();
    step(); drive(0, 0, 1, 0, 0, 0);
    @(negedge clk); chk("rst pre grant", {30'd0, grant}, 32'b10);
    #1 rst_n = 1'b0; s_ack = 1'b1;
    #1 chk_idle("async rst");
    chk("async rst ack1", {31'd0, m1_ack}, 0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk_idle("post rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
